aq_gemac_udp_packer: RTL and testbench
======================================

# aq_gemac_udp_packer

Stream-to-datagram packer that sits directly upstream of the UDP send port of the GbE MAC/UDP top, in the 125 MHz system clock domain. It buffers a continuous 32-bit word stream in an internal FIFO and slices it into UDP datagrams. A datagram is launched when the FIFO holds a full payload, when a partial payload has been idle past a timeout, or on an explicit flush. It drives the `UDP_SEND_*` request/data handshake and tracks sent packets.

## Interface
Parameters:
- `FIFO_AW`, 9: FIFO address width; depth is 2^FIFO_AW = 512 words.
- `MAX_WORDS`, 256: maximum payload per datagram in words (1024 bytes); must be ≤ 2^FIFO_AW and ≤ 16383.
- `TIMEOUT`, 12500: idle cycles before a partial payload is sent (100 µs at 125 MHz); must be ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1: system clock (125 MHz).
- `RST` in 1: asynchronous, active-high reset.
- `DIN_VALID` in 1: an input word is offered.
- `DIN_READY` out 1: the FIFO can accept a word (FIFO not full).
- `DIN_DATA` in 32: input word.
- `DIN_FLUSH` in 1: single-cycle pulse; send buffered data now.
- `SRCPORT` in 16: UDP source port; latched at datagram launch.
- `UDP_SEND_REQUEST` out 1: datagram request.
- `UDP_SEND_LENGTH` out 16: payload length in bytes.
- `UDP_SEND_SRCPORT` out 16: latched source port.
- `UDP_SEND_BUSY` in 1: the downstream controller is handling a datagram.
- `UDP_SEND_DATA_VALID` out 1: `UDP_SEND_DATA` holds a valid payload word.
- `UDP_SEND_DATA_READ` in 1: the downstream controller consumes the word.
- `UDP_SEND_DATA` out 32: FIFO head word (first-word fall-through).
- `FIFO_COUNT` out FIFO_AW+1: current FIFO occupancy.
- `PACKET_COUNT` out 16: number of datagrams completed; wraps.

## Operation
- **FIFO.** A push occurs when `DIN_VALID && DIN_READY`. A pop occurs when `UDP_SEND_DATA_READ && UDP_SEND_DATA_VALID`. A simultaneous push and pop leaves `FIFO_COUNT` unchanged. Pointers wrap modulo the depth.
- **Flush flag.** A sticky `flush_pend` bit is set by `DIN_FLUSH`. It is cleared when a datagram is launched. It is also cleared in IDLE when `FIFO_COUNT == 0`, in which case no empty datagram is sent.
- **Timeout counter.** Counts in IDLE while 0 < `FIFO_COUNT` < `MAX_WORDS`. It clears on any push and whenever the FSM leaves IDLE, and saturates at `TIMEOUT`.
- **FSM states: IDLE, REQ, XFER, DONE.**
  - **IDLE → REQ, full payload:** if `FIFO_COUNT >= MAX_WORDS`, set `len = MAX_WORDS`.
  - **IDLE → REQ, partial payload:** otherwise, if `FIFO_COUNT > 0` and (`flush_pend` or timeout reached), set `len = FIFO_COUNT` sampled this cycle.
  - On either IDLE → REQ transition: latch `SRCPORT`, set `remaining = len`, and set `UDP_SEND_LENGTH = len*4`, i.e. {len[13:0], 2'b00}.
  - **REQ:** `UDP_SEND_REQUEST = 1`, held until `UDP_SEND_BUSY == 1`, then → XFER.
  - **XFER:** `UDP_SEND_DATA_VALID = (remaining != 0) && !empty`. Each pop decrements `remaining`. When `remaining == 0` → DONE.
  - **DONE:** wait for `UDP_SEND_BUSY == 0`, increment `PACKET_COUNT`, → IDLE.
- Words pushed after launch are never included in the current datagram; `len` is frozen at launch.
- `UDP_SEND_LENGTH` and `UDP_SEND_SRCPORT` stay stable from REQ entry through DONE exit.
- A `UDP_SEND_DATA_READ` asserted while `DATA_VALID == 0` is ignored. It causes no pop and no decrement.
- `DIN_FLUSH` arriving during REQ, XFER or DONE sets `flush_pend`, which is evaluated on return to IDLE.

## Timing
- **Reset values:**
  - `DIN_READY` = 1 (FIFO empty).
  - `UDP_SEND_REQUEST`, `UDP_SEND_DATA_VALID` = 0.
  - `UDP_SEND_LENGTH`, `UDP_SEND_SRCPORT`, `FIFO_COUNT`, `PACKET_COUNT` = 0.
  - `UDP_SEND_DATA` = don't-care.
  - FSM in IDLE; `flush_pend` = 0; timeout counter = 0.
- **Reset mid-operation:** asserting `RST` at any point empties the FIFO and returns the FSM to IDLE immediately. A partly sent datagram is abandoned.
- **Launch latency:**
  - The condition true in IDLE at cycle N gives `UDP_SEND_REQUEST` = 1 at cycle N+1 (registered).
  - A push that raises `FIFO_COUNT` to `MAX_WORDS` at edge N is seen at N and requests at N+1.
- **Timeout:** the last push at cycle P, with no further push, leads to launch when the counter reaches `TIMEOUT`. `UDP_SEND_REQUEST` rises at P+TIMEOUT+1 (±1 cycle is not permitted).
- **FIFO and status latency:**
  - A word pushed at edge N is visible on `UDP_SEND_DATA` by N+1.
  - `FIFO_COUNT` and `DIN_READY` are registered and combinational respectively, and both reflect the state after edge N.
- **Full-rate streaming:** one word per cycle is sustained in XFER with `DATA_READ` held high, giving zero bubble cycles while the FIFO is non-empty.
- **Back-to-back datagrams:** DONE → IDLE → REQ is a minimum of 2 cycles after `BUSY` falls.

## Test plan
- **Full payload:** with `MAX_WORDS` = 256, push 256 words 0..255 at 1 word/cycle with the downstream always ready → one request with LENGTH = 1024 and SRCPORT as applied. 256 words are read in order, then `PACKET_COUNT` = 1 and `FIFO_COUNT` = 0.
- **Timeout launch:** push 10 words, then idle with `TIMEOUT` = 20 → request exactly 21 cycles after the last push, LENGTH = 40, words delivered in order.
- **Flush:** push 3 words and pulse `DIN_FLUSH` → request 1 cycle later with LENGTH = 12. Pulse `DIN_FLUSH` with the FIFO empty → no request and `flush_pend` clears.
- **Backpressure:** hold `BUSY` = 0 and keep pushing → `DIN_READY` drops at `FIFO_COUNT` = 512 and no word is lost. Release with the downstream ready → two 1024-byte datagrams (256 words each) in order.
- **Stalled read plus concurrent push:** toggle `DATA_READ` randomly while pushing during XFER → exactly `len` words are popped, the rest remain, and LENGTH and SRCPORT hold steady until `BUSY` falls.
- **Reset mid-operation:** assert `RST` during XFER after 100 of 256 words → all outputs return to reset values. The next 256-word payload is sent normally with `PACKET_COUNT` = 1.

Source files
------------

// File: rtl/aq_gemac_udp_packer.sv
// aq_gemac_udp_packer
//
// Buffers a continuous 32-bit word stream in a first-word-fall-through FIFO
// and slices it into UDP datagrams for the GbE MAC/UDP send port. A datagram
// is launched when a full payload (MAX_WORDS) is buffered, when a partial
// payload has sat idle for TIMEOUT cycles, or after an explicit flush.
//
// Ports
//   CLK, RST             : system clock, asynchronous active-high reset
//   DIN_VALID/READY/DATA : input word stream (READY = FIFO not full)
//   DIN_FLUSH            : one-cycle pulse, send whatever is buffered
//   SRCPORT              : UDP source port, captured at datagram launch
//   UDP_SEND_REQUEST     : datagram request, held until UDP_SEND_BUSY
//   UDP_SEND_LENGTH      : payload length in bytes (frozen at launch)
//   UDP_SEND_SRCPORT     : captured source port (frozen at launch)
//   UDP_SEND_BUSY        : downstream controller owns the datagram
//   UDP_SEND_DATA_VALID  : UDP_SEND_DATA holds a payload word
//   UDP_SEND_DATA_READ   : downstream consumes the current word
//   UDP_SEND_DATA        : FIFO head word
//   FIFO_COUNT           : FIFO occupancy
//   PACKET_COUNT         : completed datagrams, wraps
module aq_gemac_udp_packer #(
  parameter int FIFO_AW   = 9,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 12500
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DIN_VALID,
  output logic               DIN_READY,
  input  logic [31:0]        DIN_DATA,
  input  logic               DIN_FLUSH,
  input  logic [15:0]        SRCPORT,
  output logic               UDP_SEND_REQUEST,
  output logic [15:0]        UDP_SEND_LENGTH,
  output logic [15:0]        UDP_SEND_SRCPORT,
  input  logic               UDP_SEND_BUSY,
  output logic               UDP_SEND_DATA_VALID,
  input  logic               UDP_SEND_DATA_READ,
  output logic [31:0]        UDP_SEND_DATA,
  output logic [FIFO_AW:0]   FIFO_COUNT,
  output logic [15:0]        PACKET_COUNT
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXW_C  = CW'(MAX_WORDS);
  localparam logic [TW-1:0] TOUT_C  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t              state;
  state_t              state_nxt;

  logic [31:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  logic [CW-1:0]       remaining;
  logic                launch;
  logic [CW-1:0]       launch_len;
  logic                flush_pend;
  logic [TW-1:0]       tcnt;

  assign full                = (count == DEPTH_C);
  assign empty               = (count == '0);
  assign DIN_READY           = !full;
  assign push                = DIN_VALID && !full;
  assign UDP_SEND_DATA_VALID = (state == XFER) && (remaining != '0) && !empty;
  assign pop                 = UDP_SEND_DATA_READ && UDP_SEND_DATA_VALID;
  assign UDP_SEND_DATA       = mem[rd_ptr];
  assign UDP_SEND_REQUEST    = (state == REQ);
  assign FIFO_COUNT          = count;

  // FIFO storage: data only, never reset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DIN_DATA;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and launch decision. A full payload wins over a partial one;
  // the partial length is the occupancy seen in the launch cycle.
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    launch_len = '0;
    case (state)
      IDLE: begin
        if (count >= MAXW_C) begin
          launch     = 1'b1;
          launch_len = MAXW_C;
        end else if (!empty && (flush_pend || (tcnt >= TOUT_C))) begin
          launch     = 1'b1;
          launch_len = count;
        end
        if (launch) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (UDP_SEND_BUSY) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (remaining == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!UDP_SEND_BUSY) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, datagram descriptor, flush and timeout tracking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      remaining        <= '0;
      UDP_SEND_LENGTH  <= '0;
      UDP_SEND_SRCPORT <= '0;
      PACKET_COUNT     <= '0;
      flush_pend       <= 1'b0;
      tcnt             <= '0;
    end else begin
      state <= state_nxt;

      if (launch) begin
        remaining        <= launch_len;
        UDP_SEND_LENGTH  <= 16'(launch_len) << 2;
        UDP_SEND_SRCPORT <= SRCPORT;
      end else if (pop) begin
        remaining <= remaining - CW'(1);
      end

      if ((state == DONE) && !UDP_SEND_BUSY) begin
        PACKET_COUNT <= PACKET_COUNT + 16'd1;
      end

      // A flush with nothing buffered is dropped rather than producing an
      // empty datagram; a new flush pulse always re-arms the flag.
      if (launch || ((state == IDLE) && empty)) begin
        flush_pend <= 1'b0;
      end
      if (DIN_FLUSH) begin
        flush_pend <= 1'b1;
      end

      if (push || (state != IDLE) || launch) begin
        tcnt <= '0;
      end else if (!empty && (count < MAXW_C) && (tcnt < TOUT_C)) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_aq_gemac_udp_packer.sv
module tb_aq_gemac_udp_packer;

  localparam int FIFO_AW   = 9;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 20;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               DIN_VALID;
  logic               DIN_READY;
  logic [31:0]        DIN_DATA;
  logic               DIN_FLUSH;
  logic [15:0]        SRCPORT;
  logic               UDP_SEND_REQUEST;
  logic [15:0]        UDP_SEND_LENGTH;
  logic [15:0]        UDP_SEND_SRCPORT;
  logic               UDP_SEND_BUSY;
  logic               UDP_SEND_DATA_VALID;
  logic               UDP_SEND_DATA_READ;
  logic [31:0]        UDP_SEND_DATA;
  logic [FIFO_AW:0]   FIFO_COUNT;
  logic [15:0]        PACKET_COUNT;

  always #4 CLK = ~CLK;

  aq_gemac_udp_packer #(
    .FIFO_AW  (FIFO_AW),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .DIN_VALID          (DIN_VALID),
    .DIN_READY          (DIN_READY),
    .DIN_DATA           (DIN_DATA),
    .DIN_FLUSH          (DIN_FLUSH),
    .SRCPORT            (SRCPORT),
    .UDP_SEND_REQUEST   (UDP_SEND_REQUEST),
    .UDP_SEND_LENGTH    (UDP_SEND_LENGTH),
    .UDP_SEND_SRCPORT   (UDP_SEND_SRCPORT),
    .UDP_SEND_BUSY      (UDP_SEND_BUSY),
    .UDP_SEND_DATA_VALID(UDP_SEND_DATA_VALID),
    .UDP_SEND_DATA_READ (UDP_SEND_DATA_READ),
    .UDP_SEND_DATA      (UDP_SEND_DATA),
    .FIFO_COUNT         (FIFO_COUNT),
    .PACKET_COUNT       (PACKET_COUNT)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and downstream controller model
  logic [31:0] q[$];
  int          cyc = 0;
  int          last_push_cyc = 0;
  int          req_cyc = 0;
  int          n_req = 0;
  int          n_done = 0;
  int          words_left = 0;
  int          words_cur = 0;
  int          stable_err = 0;
  bit          ds_en = 1'b0;
  bit          rd_rand = 1'b0;
  logic [15:0] got_len = '0;
  logic [15:0] got_src = '0;

  task automatic step();
    logic        pushed;
    logic        popped;
    logic [31:0] exp_w;
    if (ds_en) begin
      if (!UDP_SEND_BUSY && UDP_SEND_REQUEST) begin
        UDP_SEND_BUSY = 1'b1;
        got_len       = UDP_SEND_LENGTH;
        got_src       = UDP_SEND_SRCPORT;
        words_left    = int'(UDP_SEND_LENGTH >> 2);
        words_cur     = 0;
        n_req++;
        req_cyc       = cyc;
      end else if (UDP_SEND_BUSY && (words_left == 0)) begin
        UDP_SEND_BUSY = 1'b0;
        n_done++;
      end
      UDP_SEND_DATA_READ = UDP_SEND_BUSY && (rd_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end else begin
      UDP_SEND_DATA_READ = 1'b0;
    end
    if (UDP_SEND_BUSY && ((UDP_SEND_LENGTH != got_len) || (UDP_SEND_SRCPORT != got_src))) begin
      stable_err++;
    end
    pushed = DIN_VALID && DIN_READY;
    popped = UDP_SEND_DATA_READ && UDP_SEND_DATA_VALID;
    if (popped) begin
      exp_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
      check("data", UDP_SEND_DATA, exp_w);
      words_left--;
      words_cur++;
    end
    if (pushed) begin
      q.push_back(DIN_DATA);
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (pushed) begin
      last_push_cyc = cyc;
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    DIN_VALID = 1'b1;
    DIN_DATA  = d;
    step();
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_req(input int target, input int budget);
    int k = 0;
    while ((n_req < target) && (k < budget)) begin
      step();
      k++;
    end
    check("req_arrived", 32'(n_req), 32'(target));
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while ((n_done < target) && (k < budget)) begin
      step();
      k++;
    end
    check("dgram_done", 32'(n_done), 32'(target));
    step();
    step();
  endtask

  initial begin
    int acc;
    int flush_cyc;
    int k;
    logic rdy;

    DIN_VALID          = 1'b0;
    DIN_DATA           = '0;
    DIN_FLUSH          = 1'b0;
    SRCPORT            = 16'h1234;
    UDP_SEND_BUSY      = 1'b0;
    UDP_SEND_DATA_READ = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready",  32'(DIN_READY), 32'd1);
    check("rst_req",    32'(UDP_SEND_REQUEST), 32'd0);
    check("rst_dvalid", 32'(UDP_SEND_DATA_VALID), 32'd0);
    check("rst_len",    32'(UDP_SEND_LENGTH), 32'd0);
    check("rst_src",    32'(UDP_SEND_SRCPORT), 32'd0);
    check("rst_fcnt",   32'(FIFO_COUNT), 32'd0);
    check("rst_pcnt",   32'(PACKET_COUNT), 32'd0);
    RST = 1'b0;
    step();

    // Full payload: 256 words, request the cycle after the 256th push
    ds_en = 1'b1;
    for (int i = 0; i < 256; i++) push_word(32'(i));
    check("full_fcnt", 32'(FIFO_COUNT), 32'd256);
    check("full_noreq_yet", 32'(UDP_SEND_REQUEST), 32'd0);
    wait_req(1, 5);
    check("full_lat", 32'(req_cyc - last_push_cyc), 32'd1);
    check("full_len", 32'(got_len), 32'd1024);
    check("full_src", 32'(got_src), 32'h1234);
    wait_done(1, 400);
    check("full_words", 32'(words_cur), 32'd256);
    check("full_pcnt", 32'(PACKET_COUNT), 32'd1);
    check("full_fcnt_end", 32'(FIFO_COUNT), 32'd0);

    // Timeout launch: 10 words then idle
    for (int i = 0; i < 10; i++) push_word(32'hA000_0000 + 32'(i));
    wait_req(2, 60);
    check("to_lat", 32'(req_cyc - last_push_cyc), 32'(TIMEOUT + 1));
    check("to_len", 32'(got_len), 32'd40);
    wait_done(2, 100);
    check("to_pcnt", 32'(PACKET_COUNT), 32'd2);

    // Flush with 3 words buffered
    for (int i = 0; i < 3; i++) push_word(32'hF100_0000 + 32'(i));
    DIN_FLUSH = 1'b1;
    step();
    DIN_FLUSH = 1'b0;
    flush_cyc = cyc;
    wait_req(3, 10);
    check("fl_lat", 32'(req_cyc - flush_cyc), 32'd1);
    check("fl_len", 32'(got_len), 32'd12);
    wait_done(3, 50);
    check("fl_pcnt", 32'(PACKET_COUNT), 32'd3);

    // Flush on empty FIFO: no datagram, and the flag must not linger
    DIN_FLUSH = 1'b1;
    step();
    DIN_FLUSH = 1'b0;
    repeat (30) step();
    check("efl_noreq", 32'(n_req), 32'd3);
    push_word(32'h0000_00EE);
    wait_req(4, 40);
    check("efl_lat", 32'(req_cyc - last_push_cyc), 32'(TIMEOUT + 1));
    check("efl_len", 32'(got_len), 32'd4);
    wait_done(4, 50);

    // Backpressure: downstream never takes the request
    ds_en = 1'b0;
    acc   = 0;
    for (int i = 0; i < 600; i++) begin
      DIN_VALID = 1'b1;
      DIN_DATA  = 32'hB000_0000 + 32'(acc);
      rdy       = DIN_READY;
      step();
      if (rdy) acc++;
    end
    DIN_VALID = 1'b0;
    check("bp_accepted", 32'(acc), 32'd512);
    check("bp_fcnt", 32'(FIFO_COUNT), 32'd512);
    check("bp_ready", 32'(DIN_READY), 32'd0);
    check("bp_req_held", 32'(UDP_SEND_REQUEST), 32'd1);
    ds_en = 1'b1;
    wait_req(5, 10);
    check("bp_len1", 32'(got_len), 32'd1024);
    wait_req(6, 600);
    check("bp_len2", 32'(got_len), 32'd1024);
    wait_done(6, 600);
    check("bp_pcnt", 32'(PACKET_COUNT), 32'd6);
    check("bp_fcnt_end", 32'(FIFO_COUNT), 32'd0);

    // Stalled reads with pushes during the transfer
    rd_rand = 1'b1;
    SRCPORT = 16'h5678;
    for (int i = 0; i < 50; i++) push_word(32'hC000_0000 + 32'(i));
    DIN_FLUSH = 1'b1;
    step();
    DIN_FLUSH = 1'b0;
    wait_req(7, 10);
    check("st_len", 32'(got_len), 32'd200);
    check("st_src", 32'(got_src), 32'h5678);
    SRCPORT    = 16'h9999;
    stable_err = 0;
    for (int i = 0; i < 30; i++) push_word(32'hD000_0000 + 32'(i));
    wait_done(7, 400);
    check("st_words", 32'(words_cur), 32'd50);
    check("st_left", 32'(FIFO_COUNT), 32'd30);
    check("st_stable", 32'(stable_err), 32'd0);
    check("st_pcnt", 32'(PACKET_COUNT), 32'd7);
    wait_req(8, 60);
    check("st_len2", 32'(got_len), 32'd120);
    check("st_src2", 32'(got_src), 32'h9999);
    wait_done(8, 400);
    rd_rand = 1'b0;

    // Reset in the middle of a transfer
    for (int i = 0; i < 256; i++) push_word(32'h7000_0000 + 32'(i));
    k = 0;
    while (!((n_req == 9) && (words_cur >= 100)) && (k < 400)) begin
      step();
      k++;
    end
    check("mid_words", 32'(words_cur), 32'd100);
    RST = 1'b1;
    #2;
    check("mr_req",    32'(UDP_SEND_REQUEST), 32'd0);
    check("mr_dvalid", 32'(UDP_SEND_DATA_VALID), 32'd0);
    check("mr_fcnt",   32'(FIFO_COUNT), 32'd0);
    check("mr_pcnt",   32'(PACKET_COUNT), 32'd0);
    check("mr_len",    32'(UDP_SEND_LENGTH), 32'd0);
    check("mr_src",    32'(UDP_SEND_SRCPORT), 32'd0);
    check("mr_ready",  32'(DIN_READY), 32'd1);
    q.delete();
    UDP_SEND_BUSY      = 1'b0;
    UDP_SEND_DATA_READ = 1'b0;
    words_left         = 0;
    n_req              = 0;
    n_done             = 0;
    @(posedge CLK);
    #1;
    cyc++;
    RST = 1'b0;
    step();
    for (int i = 0; i < 256; i++) push_word(32'h8000_0000 + 32'(i));
    wait_req(1, 10);
    check("ar_len", 32'(got_len), 32'd1024);
    wait_done(1, 400);
    check("ar_words", 32'(words_cur), 32'd256);
    check("ar_pcnt", 32'(PACKET_COUNT), 32'd1);
    check("ar_fcnt", 32'(FIFO_COUNT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
